// File: rtl/cam_ctrl_pkg.sv
// Shared constants and types for the tag CAM sequencer and its LRU tracker.
package cam_ctrl_pkg;
   localparam int TAG_W = 8;
   localparam int NWAYS = 4;
   localparam int IDX_W = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      COMPARE = 3'd2,
      FILL    = 3'd3,
      WRITE   = 3'd4,
      DONE    = 3'd5
   } state_t;

   typedef logic [1:0] age_t;
endpackage

// File: rtl/cam_lru.sv
// True-LRU age tracker for the four CAM ways; the way with age 3 is the victim.
module cam_lru
   import cam_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             resetn,
   input  logic             touch,
   input  logic [IDX_W-1:0] touch_way,
   output logic [IDX_W-1:0] victim
);

   age_t age_r [NWAYS];

   // Ages younger than the touched way move one step older; the touched way becomes newest.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NWAYS; i++) begin
            age_r[i] <= age_t'(i);
         end
      end else if (touch) begin
         for (int i = 0; i < NWAYS; i++) begin
            if (IDX_W'(i) == touch_way) begin
               age_r[i] <= 2'd0;
            end else if (age_r[i] < age_r[touch_way]) begin
               age_r[i] <= age_r[i] + 2'd1;
            end else begin
               age_r[i] <= age_r[i];
            end
         end
      end else begin
         for (int i = 0; i < NWAYS; i++) begin
            age_r[i] <= age_r[i];
         end
      end
   end

   // Ages always form a permutation of 0..3, so exactly one way is oldest.
   always_comb begin
      victim = {IDX_W{1'b0}};
      for (int i = 0; i < NWAYS; i++) begin
         if (age_r[i] == 2'd3) begin
            victim = IDX_W'(i);
         end else begin
            victim = victim;
         end
      end
   end

endmodule

// File: rtl/cam_tag_ctrl.sv
// Lookup/fill sequencer in front of the 4x8 tag CAM: qualifies match bits with
// local valid bits and writes missed tags into the LRU or first free way.
module cam_tag_ctrl
   import cam_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             resetn,
   input  logic             req,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic [IDX_W-1:0] way,
   output logic             err_multi,
   output logic             fill_req,
   output logic [TAG_W-1:0] fill_tag,
   output logic [IDX_W-1:0] fill_way,
   input  logic             fill_ack,
   output logic             cam_we_n,
   output logic             cam_rd_n,
   output logic [TAG_W-1:0] cam_din,
   output logic [IDX_W-1:0] cam_addrs,
   output logic [TAG_W-1:0] cam_argin,
   input  logic [NWAYS-1:0] cam_mbits
);

   state_t             state_r;
   logic [TAG_W-1:0]   tag_r;
   logic [NWAYS-1:0]   valid_r;
   logic [NWAYS-1:0]   q_s;
   logic [IDX_W-1:0]   hit_way_s;
   logic               multi_s;
   logic [IDX_W-1:0]   victim_s;
   logic [IDX_W-1:0]   lru_victim_s;
   logic               lru_touch_s;
   logic [IDX_W-1:0]   lru_way_s;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NWAYS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = NWAYS - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [2:0] popcount(input logic [NWAYS-1:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < NWAYS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   assign cam_rd_n = 1'b1;

   // Match qualification, victim choice and LRU touch selection.
   always_comb begin
      q_s       = cam_mbits & valid_r;
      hit_way_s = lowest_set(q_s);
      multi_s   = (popcount(q_s) > 3'd1);
      if (valid_r != 4'b1111) begin
         victim_s = lowest_set(~valid_r);
      end else begin
         victim_s = lru_victim_s;
      end
      if (state_r == WRITE) begin
         lru_touch_s = 1'b1;
         lru_way_s   = fill_way;
      end else begin
         lru_touch_s = (state_r == COMPARE) && (q_s != 4'b0000);
         lru_way_s   = hit_way_s;
      end
   end

   cam_lru u_lru (
      .clock     (clock),
      .resetn    (resetn),
      .touch     (lru_touch_s),
      .touch_way (lru_way_s),
      .victim    (lru_victim_s)
   );

   // Sequencer with registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         tag_r     <= 8'h00;
         valid_r   <= 4'b0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
         way       <= 2'd0;
         err_multi <= 1'b0;
         fill_req  <= 1'b0;
         fill_tag  <= 8'h00;
         fill_way  <= 2'd0;
         cam_we_n  <= 1'b1;
         cam_din   <= 8'h00;
         cam_addrs <= 2'd0;
         cam_argin <= 8'h00;
      end else begin
         done     <= 1'b0;
         cam_we_n <= 1'b1;
         case (state_r)
            IDLE: begin
               if (flush) begin
                  valid_r <= 4'b0000;
               end else if (req) begin
                  tag_r     <= req_tag;
                  cam_argin <= req_tag;
                  busy      <= 1'b1;
                  state_r   <= LOOKUP;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOOKUP: state_r <= COMPARE;
            COMPARE: begin
               if (q_s != 4'b0000) begin
                  hit       <= 1'b1;
                  way       <= hit_way_s;
                  err_multi <= multi_s;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  fill_req <= 1'b1;
                  fill_tag <= tag_r;
                  fill_way <= victim_s;
                  state_r  <= FILL;
               end
            end
            FILL: begin
               if (fill_ack) begin
                  fill_req  <= 1'b0;
                  cam_we_n  <= 1'b0;
                  cam_addrs <= fill_way;
                  cam_din   <= tag_r;
                  state_r   <= WRITE;
               end else begin
                  state_r <= FILL;
               end
            end
            WRITE: begin
               // The CAM only re-evaluates on an argument change, so park it on ~tag.
               valid_r[fill_way] <= 1'b1;
               cam_argin         <= ~tag_r;
               hit               <= 1'b0;
               err_multi         <= 1'b0;
               way               <= fill_way;
               done              <= 1'b1;
               state_r           <= DONE;
            end
            DONE: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy     <= 1'b0;
               fill_req <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_tag_ctrl.sv
// Directed bench for cam_tag_ctrl with a behavioural CAM that only refreshes
// its match bits when the argument bus changes.
module tb_cam_tag_ctrl;
   logic       clock;
   logic       resetn;
   logic       req;
   logic [7:0] req_tag;
   logic       flush;
   logic       busy;
   logic       done;
   logic       hit;
   logic [1:0] way;
   logic       err_multi;
   logic       fill_req;
   logic [7:0] fill_tag;
   logic [1:0] fill_way;
   logic       fill_ack;
   logic       cam_we_n;
   logic       cam_rd_n;
   logic [7:0] cam_din;
   logic [1:0] cam_addrs;
   logic [7:0] cam_argin;
   logic [3:0] cam_mbits;

   logic [7:0] mem [4] = '{default: 8'h00};
   logic [7:0] last_arg = 8'h00;
   logic [3:0] mbits_r = 4'b0000;
   logic       poke;
   logic [1:0] poke_way;
   logic [7:0] poke_data;
   int         we_cnt = 0;
   int         checks = 0;
   int         errors = 0;

   cam_tag_ctrl dut (
      .clock     (clock),
      .resetn    (resetn),
      .req       (req),
      .req_tag   (req_tag),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hit       (hit),
      .way       (way),
      .err_multi (err_multi),
      .fill_req  (fill_req),
      .fill_tag  (fill_tag),
      .fill_way  (fill_way),
      .fill_ack  (fill_ack),
      .cam_we_n  (cam_we_n),
      .cam_rd_n  (cam_rd_n),
      .cam_din   (cam_din),
      .cam_addrs (cam_addrs),
      .cam_argin (cam_argin),
      .cam_mbits (cam_mbits)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign cam_mbits = mbits_r;

   // CAM model: writes, test pokes, and match refresh on argument change.
   always @(posedge clock) begin
      if (poke) begin
         mem[poke_way] <= poke_data;
      end else if (!cam_we_n) begin
         mem[cam_addrs] <= cam_din;
      end
      if (cam_argin != last_arg) begin
         last_arg <= cam_argin;
         for (int i = 0; i < 4; i++) begin
            mbits_r[i] <= (mem[i] == cam_argin);
         end
      end
      if (resetn && !cam_we_n) we_cnt <= we_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_req(input logic [7:0] tag, input logic exp_hit, input logic [1:0] exp_way,
                          input logic exp_err, input int ack_wait);
      int         cyc;
      int         we0;
      logic [7:0] inv;
      inv = ~tag;
      @(negedge clock);
      req = 1'b1;
      req_tag = tag;
      @(posedge clock);
      #1 req = 1'b0;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!done && !fill_req && cyc < 40);
      check_val("first_resp_lat", cyc, 3);
      check_val("busy_active", busy, 1);
      if (exp_hit) begin
         check_val("hit_done", done, 1);
         check_val("hit_flag", hit, 1);
         check_val("hit_way", way, exp_way);
         check_val("hit_err_multi", err_multi, exp_err);
         check_val("hit_no_fill", fill_req, 0);
      end else begin
         check_val("miss_fill_req", fill_req, 1);
         check_val("miss_fill_way", fill_way, exp_way);
         check_val("miss_fill_tag", fill_tag, tag);
         check_val("miss_no_done", done, 0);
         for (int k = 0; k < ack_wait; k++) begin
            @(negedge clock);
            check_val("fill_req_held", fill_req, 1);
            check_val("fill_way_held", fill_way, exp_way);
         end
         we0 = we_cnt;
         fill_ack = 1'b1;
         @(posedge clock);
         #1 fill_ack = 1'b0;
         @(negedge clock);
         check_val("write_we_n", cam_we_n, 0);
         check_val("write_addr", cam_addrs, exp_way);
         check_val("write_din", cam_din, tag);
         check_val("write_fill_req", fill_req, 0);
         @(negedge clock);
         check_val("miss_done", done, 1);
         check_val("miss_hit", hit, 0);
         check_val("miss_way", way, exp_way);
         check_val("miss_we_n_off", cam_we_n, 1);
         check_val("argin_parked", cam_argin, inv);
         check_val("one_we_pulse", we_cnt - we0, 1);
      end
      @(negedge clock);
      check_val("done_pulse_end", done, 0);
      check_val("busy_end", busy, 0);
   endtask

   initial begin
      resetn = 1'b0;
      req = 1'b0;
      req_tag = 8'h00;
      flush = 1'b0;
      fill_ack = 1'b0;
      poke = 1'b0;
      poke_way = 2'd0;
      poke_data = 8'h00;
      #12;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_fill_req", fill_req, 0);
      check_val("rst_we_n", cam_we_n, 1);
      check_val("rst_rd_n", cam_rd_n, 1);
      check_val("rst_argin", cam_argin, 8'h00);
      check_val("rst_way", way, 0);
      @(negedge clock);
      resetn = 1'b1;

      // First miss into empty CAM, then immediate re-lookup through the parked argument.
      run_req(8'h5A, 1'b0, 2'd0, 1'b0, 2);
      run_req(8'h5A, 1'b1, 2'd0, 1'b0, 0);

      // Fill remaining ways, then a hit on way 2.
      run_req(8'h11, 1'b0, 2'd1, 1'b0, 0);
      run_req(8'h22, 1'b0, 2'd2, 1'b0, 1);
      run_req(8'h33, 1'b0, 2'd3, 1'b0, 0);
      run_req(8'h22, 1'b1, 2'd2, 1'b0, 0);

      // Access order 0,1,2,3 leaves way 0 oldest.
      run_req(8'h5A, 1'b1, 2'd0, 1'b0, 0);
      run_req(8'h11, 1'b1, 2'd1, 1'b0, 0);
      run_req(8'h22, 1'b1, 2'd2, 1'b0, 0);
      run_req(8'h33, 1'b1, 2'd3, 1'b0, 0);
      run_req(8'h44, 1'b0, 2'd0, 1'b0, 1);
      run_req(8'h44, 1'b1, 2'd0, 1'b0, 0);

      // Duplicate entry in the CAM: lowest way wins and err_multi flags it.
      @(negedge clock);
      poke = 1'b1;
      poke_way = 2'd1;
      poke_data = 8'h44;
      @(posedge clock);
      #1 poke = 1'b0;
      run_req(8'h33, 1'b1, 2'd3, 1'b0, 0);
      run_req(8'h44, 1'b1, 2'd0, 1'b1, 0);

      // Flush beats a simultaneous request.
      @(negedge clock);
      flush = 1'b1;
      req = 1'b1;
      req_tag = 8'h77;
      @(posedge clock);
      #1 begin
         flush = 1'b0;
         req = 1'b0;
      end
      @(negedge clock);
      check_val("flush_drops_req", busy, 0);
      run_req(8'h11, 1'b0, 2'd0, 1'b0, 0);

      // Reset while waiting for the fill.
      @(negedge clock);
      req = 1'b1;
      req_tag = 8'h5A;
      @(posedge clock);
      #1 req = 1'b0;
      repeat (3) @(negedge clock);
      check_val("pre_rst_fill_req", fill_req, 1);
      check_val("pre_rst_fill_way", fill_way, 1);
      #2 resetn = 1'b0;
      #1;
      check_val("async_fill_req", fill_req, 0);
      check_val("async_we_n", cam_we_n, 1);
      check_val("async_busy", busy, 0);
      @(negedge clock);
      resetn = 1'b1;
      // Tag 11 is still stored in the CAM but must miss since valid bits were cleared.
      run_req(8'h11, 1'b0, 2'd0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
